// File: rtl/ts_pkt_extract.sv
// TS packet extractor: strips marker/IP/port headers, validates sync and length,
// buffers good packets in two ping-pong banks and replays them as a byte stream.
module ts_pkt_extract #(
  parameter int         TS_WORDS  = 47,
  parameter logic [7:0] SYNC_BYTE = 8'h47
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [32:0] ts_din,
  input  logic        ts_din_en,
  output logic [7:0]  ts_dout,
  output logic        ts_dout_en,
  output logic        ts_dout_sop,
  output logic [31:0] pkt_ip,
  output logic [15:0] pkt_port,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_drop_cnt
);

  localparam int PKT_BYTES = 4 * TS_WORDS;
  localparam int IW        = $clog2(TS_WORDS);
  localparam int CW        = $clog2(PKT_BYTES);
  localparam int AW        = $clog2(2 * TS_WORDS);
  localparam logic [IW-1:0] LAST_WORD  = IW'(TS_WORDS - 1);
  localparam logic [CW-1:0] LAST_BYTE  = CW'(PKT_BYTES - 1);
  localparam logic [AW-1:0] BANK1_BASE = AW'(TS_WORDS);

  typedef enum logic [2:0] {W_IDLE, W_HDR_IP, W_HDR_PORT, W_PAYLOAD, W_DISCARD} wr_state_t;
  typedef enum logic {R_IDLE, R_READ} rd_state_t;

  wr_state_t      wr_state_r;
  logic [IW-1:0]  wr_idx_r;
  logic           wr_bank_r;
  logic [31:0]    hdr_ip_r;
  logic [15:0]    hdr_port_r;
  logic           drop_pulse_r;

  rd_state_t      rd_state_r;
  logic           rd_bank_r;
  logic [CW-1:0]  rd_cnt_r;
  logic           ok_pulse_r;

  logic [1:0]     full_r;
  logic           older_r;
  logic [31:0]    bank_ip_r   [2];
  logic [15:0]    bank_port_r [2];
  logic [31:0]    mem_r [2*TS_WORDS];

  logic           word_s;
  logic           marker_s;
  logic           fill_done_s;
  logic           rd_last_s;
  logic [1:0]     rd_free_s;
  logic [1:0]     rd_busy_s;
  logic [1:0]     free_s;
  logic [1:0]     avail_s;
  logic           rd_sel_s;
  logic [AW-1:0]  wr_addr_s;
  logic [AW-1:0]  rd_addr_s;
  logic [31:0]    rd_word_s;
  logic [7:0]     rd_byte_s;

  // Input qualification and bank availability seen by both FSMs this cycle.
  always_comb begin
    word_s      = ts_din_en & ~ts_din[32];
    marker_s    = ts_din_en & ts_din[32];
    fill_done_s = (wr_state_r == W_PAYLOAD) && word_s && (wr_idx_r == LAST_WORD);
    rd_last_s   = (rd_state_r == R_READ) && (rd_cnt_r == LAST_BYTE);
    rd_free_s   = 2'b00;
    rd_busy_s   = 2'b00;
    if (rd_last_s) begin
      rd_free_s[rd_bank_r] = 1'b1;
    end else begin
      rd_free_s = 2'b00;
    end
    if (rd_state_r == R_READ) begin
      rd_busy_s[rd_bank_r] = 1'b1;
    end else begin
      rd_busy_s = 2'b00;
    end
    // A bank emptied by the reader this cycle may be claimed by a header right now.
    free_s  = ~full_r | rd_free_s;
    avail_s = full_r & ~rd_busy_s;
    if (avail_s == 2'b11) begin
      rd_sel_s = older_r;
    end else if (avail_s[0]) begin
      rd_sel_s = 1'b0;
    end else begin
      rd_sel_s = 1'b1;
    end
  end

  // Buffer addressing and big-endian byte selection for the reader.
  always_comb begin
    wr_addr_s = wr_bank_r ? (BANK1_BASE + AW'(wr_idx_r)) : AW'(wr_idx_r);
    rd_addr_s = rd_bank_r ? (BANK1_BASE + AW'(rd_cnt_r[CW-1:2])) : AW'(rd_cnt_r[CW-1:2]);
    rd_word_s = mem_r[rd_addr_s];
    case (rd_cnt_r[1:0])
      2'd0:    rd_byte_s = rd_word_s[31:24];
      2'd1:    rd_byte_s = rd_word_s[23:16];
      2'd2:    rd_byte_s = rd_word_s[15:8];
      2'd3:    rd_byte_s = rd_word_s[7:0];
      default: rd_byte_s = 8'h00;
    endcase
  end

  // Payload storage; validity is tracked separately by full_r, so no reset needed.
  always_ff @(posedge clk) begin
    if ((wr_state_r == W_PAYLOAD) && word_s) begin
      mem_r[wr_addr_s] <= ts_din[31:0];
    end
  end

  // Header parsing, sync/length checking and bank claiming.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_r   <= W_IDLE;
      wr_idx_r     <= {IW{1'b0}};
      wr_bank_r    <= 1'b0;
      hdr_ip_r     <= 32'h0000_0000;
      hdr_port_r   <= 16'h0000;
      drop_pulse_r <= 1'b0;
    end else begin
      drop_pulse_r <= 1'b0;
      // Markers resynchronise every state; only DISCARD has already counted its drop.
      if (marker_s && (wr_state_r != W_IDLE)) begin
        wr_state_r   <= W_HDR_IP;
        drop_pulse_r <= (wr_state_r != W_DISCARD);
      end else begin
        case (wr_state_r)
          W_IDLE: begin
            if (marker_s) begin
              wr_state_r <= W_HDR_IP;
            end
          end
          W_HDR_IP: begin
            if (word_s) begin
              hdr_ip_r   <= ts_din[31:0];
              wr_state_r <= W_HDR_PORT;
            end
          end
          W_HDR_PORT: begin
            if (word_s) begin
              hdr_port_r <= ts_din[15:0];
              if (|free_s) begin
                wr_bank_r  <= free_s[0] ? 1'b0 : 1'b1;
                wr_idx_r   <= {IW{1'b0}};
                wr_state_r <= W_PAYLOAD;
              end else begin
                drop_pulse_r <= 1'b1;
                wr_state_r   <= W_DISCARD;
              end
            end
          end
          W_PAYLOAD: begin
            if (word_s) begin
              if ((wr_idx_r == {IW{1'b0}}) && (ts_din[31:24] != SYNC_BYTE)) begin
                drop_pulse_r <= 1'b1;
                wr_state_r   <= W_DISCARD;
              end else if (wr_idx_r == LAST_WORD) begin
                wr_state_r <= W_IDLE;
              end else begin
                wr_idx_r <= wr_idx_r + IW'(1);
              end
            end
          end
          W_DISCARD: wr_state_r <= W_DISCARD;
          default:   wr_state_r <= W_IDLE;
        endcase
      end
    end
  end

  // Bank full flags, per-bank header copies and fill order for the reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_r         <= 2'b00;
      older_r        <= 1'b0;
      bank_ip_r[0]   <= 32'h0000_0000;
      bank_ip_r[1]   <= 32'h0000_0000;
      bank_port_r[0] <= 16'h0000;
      bank_port_r[1] <= 16'h0000;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fill_done_s && (wr_bank_r == 1'(i))) begin
          full_r[i] <= 1'b1;
        end else if (rd_free_s[i]) begin
          full_r[i] <= 1'b0;
        end else begin
          full_r[i] <= full_r[i];
        end
      end
      if (fill_done_s) begin
        bank_ip_r[wr_bank_r]   <= hdr_ip_r;
        bank_port_r[wr_bank_r] <= hdr_port_r;
        older_r                <= avail_s[~wr_bank_r] ? ~wr_bank_r : wr_bank_r;
      end
    end
  end

  // Byte replay: one byte per cycle, chaining straight into the other bank if it is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_r  <= R_IDLE;
      rd_bank_r   <= 1'b0;
      rd_cnt_r    <= {CW{1'b0}};
      ok_pulse_r  <= 1'b0;
      ts_dout     <= 8'h00;
      ts_dout_en  <= 1'b0;
      ts_dout_sop <= 1'b0;
      pkt_ip      <= 32'h0000_0000;
      pkt_port    <= 16'h0000;
    end else begin
      ok_pulse_r <= 1'b0;
      case (rd_state_r)
        R_IDLE: begin
          ts_dout_en  <= 1'b0;
          ts_dout_sop <= 1'b0;
          if (|avail_s) begin
            rd_state_r <= R_READ;
            rd_bank_r  <= rd_sel_s;
            rd_cnt_r   <= {CW{1'b0}};
          end
        end
        R_READ: begin
          ts_dout     <= rd_byte_s;
          ts_dout_en  <= 1'b1;
          ts_dout_sop <= (rd_cnt_r == {CW{1'b0}});
          pkt_ip      <= bank_ip_r[rd_bank_r];
          pkt_port    <= bank_port_r[rd_bank_r];
          if (rd_last_s) begin
            ok_pulse_r <= 1'b1;
            rd_cnt_r   <= {CW{1'b0}};
            if (avail_s[~rd_bank_r]) begin
              rd_bank_r <= ~rd_bank_r;
            end else begin
              rd_state_r <= R_IDLE;
            end
          end else begin
            rd_cnt_r <= rd_cnt_r + CW'(1);
          end
        end
        default: rd_state_r <= R_IDLE;
      endcase
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_ok_cnt   <= 16'h0000;
      pkt_drop_cnt <= 16'h0000;
    end else begin
      if (ok_pulse_r && (pkt_ok_cnt != 16'hFFFF)) begin
        pkt_ok_cnt <= pkt_ok_cnt + 16'h0001;
      end
      if (drop_pulse_r && (pkt_drop_cnt != 16'hFFFF)) begin
        pkt_drop_cnt <= pkt_drop_cnt + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_ts_pkt_extract.sv
// Bench for ts_pkt_extract: directed scenarios followed by randomized packets,
// all checked against a packet-level model of what should come out.
module tb_ts_pkt_extract;

  localparam int TSW = 47;
  localparam int NB  = 4 * TSW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] ts_din = 33'h0;
  logic        ts_din_en = 1'b0;
  logic [7:0]  ts_dout;
  logic        ts_dout_en;
  logic        ts_dout_sop;
  logic [31:0] pkt_ip;
  logic [15:0] pkt_port;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  // Model: packets expected out, in order, plus expected counter values.
  logic [31:0] exp_ip[$];
  logic [15:0] exp_port[$];
  logic [31:0] exp_words[$];
  int          exp_ok = 0;
  int          exp_drop = 0;

  // What the output monitor has collected.
  logic [31:0] rx_ip[$];
  logic [15:0] rx_port[$];
  logic [7:0]  rx_bytes[$];
  int          rx_sop[$];
  int          cur_n = 0;
  logic        in_pkt = 1'b0;
  logic [31:0] cur_ip = 32'h0;
  logic [15:0] cur_port = 16'h0;
  logic [7:0]  cur_bytes[$];

  logic [31:0] pw [TSW];

  ts_pkt_extract dut (
    .clk          (clk),
    .rst          (rst),
    .ts_din       (ts_din),
    .ts_din_en    (ts_din_en),
    .ts_dout      (ts_dout),
    .ts_dout_en   (ts_dout_en),
    .ts_dout_sop  (ts_dout_sop),
    .pkt_ip       (pkt_ip),
    .pkt_port     (pkt_port),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, expv);
    end
  endtask

  // Output monitor: assembles bytes into packets and checks framing on the fly.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_n = 0;
        in_pkt = 1'b0;
        cur_bytes.delete();
      end else begin
        if (in_pkt) begin
          checks++;
          assert (ts_dout_en === 1'b1) else begin
            errors++;
            $error("FAIL out_gap got en=%b at byte %0d expected 1", ts_dout_en, cur_n);
            in_pkt = 1'b0;
            cur_n = 0;
            cur_bytes.delete();
          end
        end
        if (ts_dout_en === 1'b1) begin
          checks++;
          assert (in_pkt || (ts_dout_sop === 1'b1)) else begin
            errors++;
            $error("FAIL byte_no_sop got sop=%b outside packet expected 1", ts_dout_sop);
          end
          if (ts_dout_sop === 1'b1) begin
            checks++;
            assert (in_pkt === 1'b0) else begin
              errors++;
              $error("FAIL sop_mid_pkt got sop at byte %0d expected byte 0", cur_n);
            end
            in_pkt = 1'b1;
            cur_n = 0;
            cur_bytes.delete();
            cur_ip = pkt_ip;
            cur_port = pkt_port;
            rx_sop.push_back(cyc);
          end else if (in_pkt) begin
            checks++;
            assert ((pkt_ip === cur_ip) && (pkt_port === cur_port)) else begin
              errors++;
              $error("FAIL sideband_stable got %h/%h expected %h/%h", pkt_ip, pkt_port, cur_ip, cur_port);
            end
          end
          if (in_pkt) begin
            cur_bytes.push_back(ts_dout);
            cur_n++;
            if (cur_n == NB) begin
              rx_ip.push_back(cur_ip);
              rx_port.push_back(cur_port);
              foreach (cur_bytes[k]) rx_bytes.push_back(cur_bytes[k]);
              in_pkt = 1'b0;
              cur_n = 0;
              cur_bytes.delete();
            end
          end
        end
      end
    end
  end

  // One input word; idle cycles carry random junk (including marker bits) with en low.
  task automatic drive(input logic [32:0] w, input int gap);
    ts_din = w;
    ts_din_en = 1'b1;
    last_cyc = cyc;
    @(negedge clk);
    ts_din_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      ts_din = 33'({$urandom(), $urandom()});
      @(negedge clk);
    end
  endtask

  // gap < 0 picks a random 0..2 idle cycles after each word.
  task automatic send_pkt(input logic [31:0] ip, input logic [15:0] port, input int n, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    drive({1'b1, $urandom()}, g);
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    drive({1'b0, ip}, g);
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    drive({1'b0, 16'($urandom()), port}, g);
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      drive({1'b0, pw[i]}, g);
    end
  endtask

  task automatic expect_good(input logic [31:0] ip, input logic [15:0] port);
    exp_ip.push_back(ip);
    exp_port.push_back(port);
    for (int i = 0; i < TSW; i++) exp_words.push_back(pw[i]);
    exp_ok++;
  endtask

  task automatic fill_good();
    pw[0] = 32'h4740_3000;
    for (int i = 1; i < TSW; i++) pw[i] = 32'(i - 1);
  endtask

  task automatic fill_random(input bit good_sync);
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h47) b = 8'h46;
    pw[0] = {good_sync ? 8'h47 : b, 24'($urandom())};
    for (int i = 1; i < TSW; i++) pw[i] = $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ts_din_en = 1'b0;
    repeat (3) @(negedge clk);
    exp_ip.delete(); exp_port.delete(); exp_words.delete();
    rx_ip.delete(); rx_port.delete(); rx_bytes.delete(); rx_sop.delete();
    exp_ok = 0;
    exp_drop = 0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int t;
    t = 0;
    while ((rx_ip.size() != exp_ip.size()) && (t < 3000)) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_pkt_count"}, rx_ip.size(), exp_ip.size());
  endtask

  task automatic wait_outstanding();
    int t;
    t = 0;
    while ((exp_ip.size() - rx_ip.size() > 1) && (t < 1000)) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Expected sop comes 3 of our cycle counts after the drive of the last word.
  task automatic check_latency(input string tag, input int n0);
    int t;
    int lat;
    t = 0;
    while ((rx_sop.size() <= n0) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    lat = (rx_sop.size() > n0) ? (rx_sop[n0] - last_cyc) : -1;
    chk({tag, "_sop_latency"}, 32'(lat), 32'd3);
  endtask

  task automatic compare_all(input string tag);
    logic [31:0] eip;
    logic [15:0] eport;
    logic [31:0] ew [TSW];
    logic [7:0]  rb [NB];
    logic [31:0] tmp;
    logic [7:0]  eb [NB];
    int d;
    while ((rx_ip.size() > 0) && (exp_ip.size() > 0)) begin
      eip = exp_ip.pop_front();
      eport = exp_port.pop_front();
      for (int i = 0; i < TSW; i++) ew[i] = exp_words.pop_front();
      for (int b = 0; b < NB; b++) begin
        rb[b] = rx_bytes.pop_front();
        tmp = ew[b / 4];
        eb[b] = tmp[8 * (3 - (b % 4)) +: 8];
      end
      chk({tag, "_ip"}, rx_ip.pop_front(), eip);
      chk({tag, "_port"}, rx_port.pop_front(), eport);
      d = NB - 1;
      for (int b = NB - 1; b >= 0; b--) if (rb[b] !== eb[b]) d = b;
      chk({tag, "_bytes"}, rb[d], eb[d]);
    end
    chk({tag, "_leftover"}, rx_ip.size() + exp_ip.size(), 32'd0);
  endtask

  task automatic check_cnt(input string tag);
    chk({tag, "_ok_cnt"}, pkt_ok_cnt, 16'(exp_ok));
    chk({tag, "_drop_cnt"}, pkt_drop_cnt, 16'(exp_drop));
  endtask

  initial begin
    int n0;
    int t;
    int kind;
    int n;
    logic [31:0] rip;
    logic [15:0] rport;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", ts_dout, 8'h00);
    chk("rst_en", ts_dout_en, 1'b0);
    chk("rst_sop", ts_dout_sop, 1'b0);
    chk("rst_ip", pkt_ip, 32'h0);
    chk("rst_port", pkt_port, 16'h0);
    chk("rst_ok", pkt_ok_cnt, 16'h0);
    chk("rst_drop", pkt_drop_cnt, 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Good packet
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E20);
    check_latency("good", 0);
    wait_drain("good");
    chk("good_first_byte", (rx_bytes.size() >= NB) ? rx_bytes[0] : 8'h00, 8'h47);
    chk("good_last_byte", (rx_bytes.size() >= NB) ? rx_bytes[NB-1] : 8'h00, 8'h2D);
    chk("good_ip_const", (rx_ip.size() > 0) ? rx_ip[0] : 32'h0, 32'hC012_0808);
    chk("good_port_const", (rx_port.size() > 0) ? rx_port[0] : 16'h0, 16'h4E20);
    compare_all("good");
    check_cnt("good");

    // Bad sync, then a good packet
    do_reset();
    fill_good();
    pw[0] = 32'h4640_3000;
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    exp_drop++;
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E20);
    wait_drain("badsync");
    compare_all("badsync");
    check_cnt("badsync");

    // Short packet aborted by the next marker
    do_reset();
    fill_good();
    send_pkt(32'h0A00_0001, 16'h1234, 20, 0);
    exp_drop++;
    send_pkt(32'hC012_0808, 16'h4E21, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E21);
    wait_drain("short");
    compare_all("short");
    check_cnt("short");

    // Overflow: third back-to-back packet has no bank
    do_reset();
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E20);
    send_pkt(32'hC012_0808, 16'h4E21, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E21);
    send_pkt(32'hC012_0808, 16'h4E22, TSW, 0);
    exp_drop++;
    wait_drain("overflow");
    chk("overflow_b2b", (rx_sop.size() >= 2) ? 32'(rx_sop[1] - rx_sop[0]) : 32'h0, 32'(NB));
    compare_all("overflow");
    check_cnt("overflow");

    // Gapped input
    do_reset();
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 1);
    expect_good(32'hC012_0808, 16'h4E20);
    check_latency("gapped", 0);
    wait_drain("gapped");
    compare_all("gapped");
    check_cnt("gapped");

    // Reset in the middle of output
    do_reset();
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    t = 0;
    while ((cur_n < 100) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    chk("midrst_reached_byte100", (cur_n >= 100) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_en", ts_dout_en, 1'b0);
    chk("midrst_sop", ts_dout_sop, 1'b0);
    chk("midrst_dout", ts_dout, 8'h00);
    chk("midrst_ip", pkt_ip, 32'h0);
    chk("midrst_port", pkt_port, 16'h0);
    chk("midrst_ok", pkt_ok_cnt, 16'h0);
    @(negedge clk);
    do_reset();
    fill_good();
    send_pkt(32'hC012_0808, 16'h4E20, TSW, 0);
    expect_good(32'hC012_0808, 16'h4E20);
    wait_drain("postrst");
    compare_all("postrst");
    check_cnt("postrst");

    // Randomized mix of good, bad-sync and short packets
    do_reset();
    for (int p = 0; p < 14; p++) begin
      wait_outstanding();
      kind = int'($urandom_range(0, 9));
      rip = $urandom();
      rport = 16'($urandom());
      if (kind < 6) begin
        fill_random(1'b1);
        send_pkt(rip, rport, TSW, (kind < 3) ? 0 : -1);
        expect_good(rip, rport);
      end else if (kind < 8) begin
        fill_random(1'b0);
        send_pkt(rip, rport, TSW, -1);
        exp_drop++;
      end else begin
        fill_random(1'b1);
        n = int'($urandom_range(0, TSW - 1));
        send_pkt(rip, rport, n, -1);
        exp_drop++;
      end
      // Trailing words after a finished or discarded packet are ignored.
      if (kind < 8) begin
        for (int j = 0; j < int'($urandom_range(0, 3)); j++) drive({1'b0, $urandom()}, 0);
      end
    end
    wait_outstanding();
    fill_random(1'b1);
    rip = $urandom();
    rport = 16'($urandom());
    send_pkt(rip, rport, TSW, 0);
    expect_good(rip, rport);
    wait_drain("random");
    compare_all("random");
    check_cnt("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
